// File: rtl/pong_pkg.sv
// Shared types for the pong display path: scan FSM encoding and PWM resolution.
package pong_pkg;

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_BLANK, S_SHOW} scan_state_t;

    localparam int PWM_STEPS = 16;

endpackage

// File: rtl/led_matrix_scan.sv
// Column-multiplexed LED matrix driver: snapshots the pong screen once per frame,
// lights one column at a time with blanking gaps and a 16-step PWM duty per dwell.
module led_matrix_scan
    import pong_pkg::*;
#(
    parameter int WIDTH        = 32,
    parameter int HEIGHT       = 32,
    parameter int DWELL_CYCLES = 1024,
    parameter int BLANK_CYCLES = 16
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           en,
    input  logic [WIDTH-1:0][HEIGHT-1:0]   screen,
    input  logic [3:0]                     bright,
    output logic [WIDTH-1:0]               col_sel,
    output logic [HEIGHT-1:0]              row_data,
    output logic                           frame_start,
    output logic [1:0]                     state_dbg
);

    localparam int COL_W   = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam int CMP_W   = $clog2(DWELL_CYCLES + 1);
    localparam int TMR_MAX = (DWELL_CYCLES > BLANK_CYCLES) ? DWELL_CYCLES : BLANK_CYCLES;
    localparam int TMR_W   = (TMR_MAX > 1) ? $clog2(TMR_MAX) : 1;
    localparam int STEP    = DWELL_CYCLES / PWM_STEPS;

    localparam logic [TMR_W-1:0] TMR_BLANK = TMR_W'(BLANK_CYCLES - 1);
    localparam logic [TMR_W-1:0] TMR_DWELL = TMR_W'(DWELL_CYCLES - 1);
    localparam logic [COL_W-1:0] COL_LAST  = COL_W'(WIDTH - 1);

    scan_state_t                  state, state_n;
    logic [TMR_W-1:0]             timer, timer_n;
    logic [COL_W-1:0]             col, col_n;
    logic [WIDTH-1:0][HEIGHT-1:0] shadow;
    logic [3:0]                   bright_q;

    logic [CMP_W-1:0]             t_show;
    logic [CMP_W-1:0]             duty;
    logic [WIDTH-1:0]             col_sel_n;
    logic [HEIGHT-1:0]            row_data_n;

    // The single timer counts down and is reloaded whenever BLANK or SHOW is entered.
    always_comb begin
        state_n = state;
        timer_n = (timer != '0) ? timer - TMR_W'(1) : '0;
        col_n   = col;
        case (state)
            S_IDLE: begin
                if (en) state_n = S_LOAD;
            end
            S_LOAD: begin
                state_n = S_BLANK;
                timer_n = TMR_BLANK;
                col_n   = '0;
            end
            S_BLANK: begin
                if (timer == '0) begin
                    state_n = S_SHOW;
                    timer_n = TMR_DWELL;
                end
            end
            S_SHOW: begin
                if (timer == '0) begin
                    timer_n = TMR_BLANK;
                    if (col == COL_LAST) begin
                        state_n = S_LOAD;
                    end else begin
                        col_n   = col + COL_W'(1);
                        state_n = S_BLANK;
                    end
                end
            end
            default: state_n = S_IDLE;
        endcase
        if (!en) state_n = S_IDLE;
    end

    // Outputs are computed from the next state so the registered drive lines up with it.
    always_comb begin
        t_show     = CMP_W'(DWELL_CYCLES - 1) - CMP_W'(timer_n);
        duty       = CMP_W'({1'b0, bright_q} + 5'd1) * CMP_W'(STEP);
        col_sel_n  = '0;
        row_data_n = '0;
        if (state_n == S_SHOW) begin
            col_sel_n = WIDTH'(1) << col_n;
            if (t_show < duty) row_data_n = shadow[col_n];
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= S_IDLE;
            timer       <= '0;
            col         <= '0;
            shadow      <= '0;
            bright_q    <= '0;
            col_sel     <= '0;
            row_data    <= '0;
            frame_start <= 1'b0;
        end else begin
            state       <= state_n;
            timer       <= timer_n;
            col         <= col_n;
            col_sel     <= col_sel_n;
            row_data    <= row_data_n;
            frame_start <= (state_n == S_LOAD);
            if (state == S_LOAD) begin
                shadow   <= screen;
                bright_q <= bright;
            end
        end
    end

    assign state_dbg = state;

endmodule
